layer_conv_mac_array: RTL and testbench
=======================================

// Module: layer_conv_mac_array
// PURPOSE
//  Parametrised, pipelined successor to the layer-1 combinational dot-product array. Each accepted beat
//  carries IN_CH fixed-point input words plus OUT_CH x IN_CH weights; the block multiplies, rescales,
//  sums across input channels and accumulates over TAPS beats (one conv kernel window). It then adds a
//  per-channel bias, optionally applies ReLU, saturates and presents OUT_CH results with valid/ready.
// PARAMETERS
//  IN_CH     3   input channels per beat
//  OUT_CH    8   output channels (filters) computed in parallel
//  W         16  word length (signed two's complement)
//  FRAC      10  fractional bits of all words (1.0 = 1<<FRAC)
//  TAPS      9   beats accumulated per result (kernel taps); must be >= 1
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  clear      in   1              sync abort of current accumulation
//  relu_en    in   1              1: negative results forced to 0
//  bias       in   OUT_CH*W       per-channel bias; channel 0 in MSBs; sampled on last-tap stage-2 edge
//  in_valid   in   1              beat present
//  in_ready   out  1              beat accepted when in_valid && in_ready
//  in_data    in   IN_CH*W        input words; word k at [(IN_CH-k)*W-1 -: W]
//  weight     in   OUT_CH*IN_CH*W weights; filter o block MSB-first, in-block packing as in_data
//  out_valid  out  1              result present
//  out_ready  in   1              result consumed when out_valid && out_ready
//  out_data   out  OUT_CH*W       results; channel 0 in MSBs
//  tap_idx    out  clog2(TAPS)    index of next beat to be accepted (0..TAPS-1)
// BEHAVIOUR
//  Reset (rst_n low, async): out_valid=0, out_data=0, tap_idx=0, accumulators=0, stage-1 valid=0.
//  Arithmetic: product = W x W signed -> 2W bits; term = product >>> FRAC (floor), kept at 2W-FRAC bits
//   (no intermediate truncation). Beat sum per filter = sum of IN_CH terms. Accumulator width
//   ACC_W = 2W-FRAC + clog2(IN_CH*TAPS) + 1; never wraps. Final = acc + sign-extended bias;
//   relu_en && Final<0 -> 0; then clamp to [-2^(W-1), 2^(W-1)-1].
//  Pipeline: stall = out_valid && !out_ready; in_ready = !stall && !clear.
//   Edge 1 (accept): stage-1 register captures per-filter beat sums, last-tap flag; tap_idx advances,
//    wraps TAPS-1 -> 0.
//   Edge 2: non-last beat: acc += beat sum. Last beat: out_data <= sat(acc+beat sum+bias), out_valid<=1,
//    acc <= 0. Latency: last beat accepted in cycle t -> out_valid high in cycle t+2.
//   While stall, stage 1, accumulators, tap_idx and out_data hold; no beat is lost or duplicated.
//   Result consumed with no new result same edge -> out_valid<=0. Consume and new result same edge ->
//    out_valid stays 1 with new data (back-to-back full throughput, TAPS=1 gives 1 result/cycle).
//  clear=1: tap_idx<=0, acc<=0, stage-1 valid<=0; concurrent beat not accepted (in_ready=0); out_data/
//   out_valid untouched. clear during stall takes effect the same edge.
//  rst_n asserted mid-window discards partial accumulation; first beat after release is tap 0.
//  out_data stable whenever out_valid && !out_ready.
// TESTING (defaults; 1.0=0x0400)
//  1 9 beats, all in/weights 0x0400, bias 0, out_ready=1 -> each channel 0x6C00 (27.0), out_valid
//    asserted exactly 2 cycles after 9th accept, one cycle wide.
//  2 in 0x0800, weights 0x0800 (108.0) -> 0x7FFF; in 0xF800, weights 0x0800 (-108.0) -> 0x8000.
//  3 in 0x0400, weights 0xFC00, bias 0 -> 0x9400 (-27.0); same with relu_en=1 -> 0x0000;
//    relu_en=0, bias 0x0800 on channel 3 only -> channel 3 = 0x9C00.
//  4 out_ready low for 20 cycles after a result, in_valid kept high with 18 beats -> out_data stable,
//    in_ready drops, then two further results 0x6C00 with no lost/extra beats.
//  5 4 beats, clear pulse (in_valid high that cycle), 9 beats of test 1 -> 0x6C00, tap_idx 0 after clear.
//  6 rst_n low after 5 beats -> out_valid/out_data/tap_idx 0 immediately; 9 fresh beats -> 0x6C00.

Source files
------------

// File: rtl/layer_conv_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : layer_conv_mac_array
// Description : Pipelined multi-filter MAC array. Each accepted beat is
//               multiplied against OUT_CH x IN_CH weights, rescaled and
//               summed per filter, then accumulated over TAPS beats. Bias,
//               optional ReLU and saturation produce OUT_CH results that are
//               presented with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_conv_mac_array #(
   parameter  int IN_CH  = 3,
   parameter  int OUT_CH = 8,
   parameter  int W      = 16,
   parameter  int FRAC   = 10,
   parameter  int TAPS   = 9,
   localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       relu_en,
   input  logic [OUT_CH*W-1:0]        bias,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_CH*W-1:0]         in_data,
   input  logic [OUT_CH*IN_CH*W-1:0]  weight,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_CH*W-1:0]        out_data,
   output logic [TAP_W-1:0]           tap_idx
);

   // Rescaled product width, and an accumulator wide enough that a full
   // window of worst-case terms can never wrap.
   localparam int TERM_W = 2*W - FRAC;
   localparam int ACC_W  = TERM_W + $clog2(IN_CH*TAPS) + 1;
   localparam int FIN_W  = ACC_W + 1;

   localparam logic signed [FIN_W-1:0] MAX_V    = FIN_W'((2**(W-1)) - 1);
   localparam logic signed [FIN_W-1:0] MIN_V    = ~MAX_V;
   localparam logic [TAP_W-1:0]        LAST_TAP = TAP_W'(TAPS - 1);

   // Full-precision product, floored by FRAC bits, sign-extended to ACC_W.
   function automatic logic signed [ACC_W-1:0] mul_term(
      input logic signed [W-1:0] a,
      input logic signed [W-1:0] b
   );
      logic signed [2*W-1:0] p;
      p = a * b;
      return {{(ACC_W-TERM_W){p[2*W-1]}}, p[2*W-1:FRAC]};
   endfunction

   // Window total plus bias, then ReLU, then clamp to the output word range.
   function automatic logic [W-1:0] finish_word(
      input logic signed [ACC_W-1:0] acc,
      input logic signed [ACC_W-1:0] sum,
      input logic signed [W-1:0]     b,
      input logic                    relu
   );
      logic signed [FIN_W-1:0] f;
      f = FIN_W'(acc) + FIN_W'(sum) + FIN_W'(b);
      if (relu && (f < 0)) begin
         return '0;
      end else if (f > MAX_V) begin
         return MAX_V[W-1:0];
      end else if (f < MIN_V) begin
         return MIN_V[W-1:0];
      end
      return f[W-1:0];
   endfunction

   logic [TAP_W-1:0]        tap_q, tap_d;
   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_last_q, s1_last_d;
   logic signed [ACC_W-1:0] s1_sum_q [OUT_CH];
   logic signed [ACC_W-1:0] s1_sum_d [OUT_CH];
   logic signed [ACC_W-1:0] acc_q    [OUT_CH];
   logic signed [ACC_W-1:0] acc_d    [OUT_CH];
   logic signed [ACC_W-1:0] beat_sum [OUT_CH];
   logic                    out_valid_q, out_valid_d;
   logic [OUT_CH*W-1:0]     out_data_q, out_data_d;
   logic [OUT_CH*W-1:0]     result;
   logic                    stall;
   logic                    accept;

   assign stall     = out_valid_q && !out_ready;
   assign in_ready  = !stall && !clear;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign tap_idx   = tap_q;

   // Per-filter sum of the rescaled products of the incoming beat.
   always_comb begin
      for (int o = 0; o < OUT_CH; o++) begin
         beat_sum[o] = '0;
         for (int k = 0; k < IN_CH; k++) begin
            beat_sum[o] = beat_sum[o] +
               mul_term(in_data[(IN_CH-k)*W-1 -: W],
                        weight[((OUT_CH-o)*IN_CH-k)*W-1 -: W]);
         end
      end
   end

   // Finished output words for a last-tap beat sitting in stage 1.
   always_comb begin
      result = '0;
      for (int o = 0; o < OUT_CH; o++) begin
         result[(OUT_CH-o)*W-1 -: W] = finish_word(acc_q[o], s1_sum_q[o],
                                                   bias[(OUT_CH-o)*W-1 -: W],
                                                   relu_en);
      end
   end

   // Next-state: clear aborts the window, stall freezes the pipeline,
   // otherwise stage 1 captures the beat and stage 2 accumulates or emits.
   always_comb begin
      tap_d       = tap_q;
      s1_valid_d  = s1_valid_q;
      s1_last_d   = s1_last_q;
      s1_sum_d    = s1_sum_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (clear) begin
         tap_d      = '0;
         s1_valid_d = 1'b0;
         for (int o = 0; o < OUT_CH; o++) begin
            acc_d[o] = '0;
         end
      end else if (!stall) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_last_d = (tap_q == LAST_TAP);
            s1_sum_d  = beat_sum;
            tap_d     = (tap_q == LAST_TAP) ? '0 : tap_q + TAP_W'(1);
         end
         if (s1_valid_q) begin
            if (s1_last_q) begin
               out_data_d  = result;
               out_valid_d = 1'b1;
               for (int o = 0; o < OUT_CH; o++) begin
                  acc_d[o] = '0;
               end
            end else begin
               for (int o = 0; o < OUT_CH; o++) begin
                  acc_d[o] = acc_q[o] + s1_sum_q[o];
               end
            end
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int o = 0; o < OUT_CH; o++) begin
            s1_sum_q[o] <= '0;
            acc_q[o]    <= '0;
         end
      end else begin
         tap_q       <= tap_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         s1_sum_q    <= s1_sum_d;
         acc_q       <= acc_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_layer_conv_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_conv_mac_array
// Description : Self-checking bench for layer_conv_mac_array. A window-level
//               arithmetic model predicts every result; directed steps cover
//               latency, saturation, ReLU, bias, stall, clear and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_conv_mac_array;
   localparam int IN_CH  = 3;
   localparam int OUT_CH = 8;
   localparam int W      = 16;
   localparam int FRAC   = 10;
   localparam int TAPS   = 9;
   localparam int TAP_W  = $clog2(TAPS);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic relu_en = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [OUT_CH*W-1:0]       bias = '0;
   logic [IN_CH*W-1:0]        in_data = '0;
   logic [OUT_CH*IN_CH*W-1:0] weight = '0;
   logic                      in_ready;
   logic                      out_valid;
   logic [OUT_CH*W-1:0]       out_data;
   logic [TAP_W-1:0]          tap_idx;

   int  tests = 0;
   int  fails = 0;
   int  results_seen = 0;
   bit  rand_ready = 1'b0;
   longint win_acc [OUT_CH];
   int  win_cnt = 0;
   logic [OUT_CH*W-1:0] exp_q [$];
   logic [OUT_CH*W-1:0] last_out = '0;

   always #5 clk = ~clk;

   layer_conv_mac_array #(
      .IN_CH(IN_CH), .OUT_CH(OUT_CH), .W(W), .FRAC(FRAC), .TAPS(TAPS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .relu_en(relu_en),
      .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .weight(weight), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .tap_idx(tap_idx)
   );

   function automatic longint sval(input logic [W-1:0] v);
      return longint'(signed'(v));
   endfunction

   // Bias, ReLU and clamp applied to an exact window total.
   function automatic logic [W-1:0] model_word(input longint total, input bit relu);
      longint f;
      logic [63:0] u;
      f = total;
      if (relu && f < 0) f = 0;
      if (f > 32767) f = 32767;
      if (f < -32768) f = -32768;
      u = f;
      return u[W-1:0];
   endfunction

   // Reference model and output checker, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         win_cnt = 0;
         foreach (win_acc[o]) win_acc[o] = 0;
         exp_q.delete();
      end else begin
         if (out_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
               assert (out_valid === 1'b0) else begin
                  fails++;
                  $error("FAIL unexpected_result obs=%h exp=none", out_data);
               end
            end else begin
               assert (out_data === exp_q[0]) else begin
                  fails++;
                  $error("FAIL out_data obs=%h exp=%h", out_data, exp_q[0]);
               end
               if (out_ready) begin
                  last_out = exp_q[0];
                  void'(exp_q.pop_front());
                  results_seen++;
               end
            end
         end
         if (clear) begin
            win_cnt = 0;
            foreach (win_acc[o]) win_acc[o] = 0;
         end else if (in_valid && in_ready) begin
            for (int o = 0; o < OUT_CH; o++)
               for (int k = 0; k < IN_CH; k++)
                  win_acc[o] += (sval(in_data[(IN_CH-k)*W-1 -: W]) *
                                 sval(weight[((OUT_CH-o)*IN_CH-k)*W-1 -: W])) >>> FRAC;
            win_cnt++;
            if (win_cnt == TAPS) begin
               logic [OUT_CH*W-1:0] e;
               e = '0;
               for (int o = 0; o < OUT_CH; o++)
                  e[(OUT_CH-o)*W-1 -: W] =
                     model_word(win_acc[o] + sval(bias[(OUT_CH-o)*W-1 -: W]), relu_en);
               exp_q.push_back(e);
               win_cnt = 0;
               foreach (win_acc[o]) win_acc[o] = 0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_uniform(input logic [W-1:0] x, input logic [W-1:0] w);
      in_data = {IN_CH{x}};
      weight  = {(OUT_CH*IN_CH){w}};
   endtask

   // Hold the current beat until accepted (bounded).
   task automatic push_beat();
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      tests++;
      assert (ok === 1'b1) else begin
         fails++;
         $error("FAIL beat_accept obs=%0b exp=1", ok);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         tick();
         n++;
      end
      tests++;
      assert (exp_q.size() === 0) else begin
         fails++;
         $error("FAIL drain obs=%0d pending exp=0", exp_q.size());
      end
      repeat (2) tick();
   endtask

   function automatic logic [W-1:0] rnd_word(input int span);
      return W'($urandom_range(0, 2*span - 1) - span);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [OUT_CH*W-1:0] v;
      int r0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, '0);
      chk("rst_tap", tap_idx, '0);
      rst_n = 1'b1;
      tick();

      // 1: unity window, exact two-cycle latency, one-cycle pulse
      set_uniform(16'h0400, 16'h0400);
      repeat (9) push_beat();
      chk("t1_lat1", out_valid, 1'b0);
      tick();
      chk("t1_lat2", out_valid, 1'b1);
      chk("t1_data", out_data, {OUT_CH{16'h6C00}});
      tick();
      chk("t1_width", out_valid, 1'b0);
      drain();

      // 2: positive and negative saturation
      set_uniform(16'h0800, 16'h0800);
      repeat (9) push_beat();
      drain();
      chk("t2_sat_pos", last_out, {OUT_CH{16'h7FFF}});
      set_uniform(16'hF800, 16'h0800);
      repeat (9) push_beat();
      drain();
      chk("t2_sat_neg", last_out, {OUT_CH{16'h8000}});

      // 3: negative result, ReLU, single-channel bias
      set_uniform(16'h0400, 16'hFC00);
      repeat (9) push_beat();
      drain();
      chk("t3_neg", last_out, {OUT_CH{16'h9400}});
      relu_en = 1'b1;
      repeat (9) push_beat();
      drain();
      chk("t3_relu", last_out, '0);
      relu_en = 1'b0;
      bias = '0;
      bias[(OUT_CH-3)*W-1 -: W] = 16'h0800;
      repeat (9) push_beat();
      drain();
      v = {OUT_CH{16'h9400}};
      v[(OUT_CH-3)*W-1 -: W] = 16'h9C00;
      chk("t3_bias", last_out, v);
      bias = '0;

      // 4: long back-pressure with continuous input
      set_uniform(16'h0400, 16'h0400);
      out_ready = 1'b0;
      r0 = results_seen;
      fork
         begin
            repeat (18) push_beat();
         end
         begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
               tick();
               n++;
            end
            chk("t4_valid", out_valid, 1'b1);
            repeat (20) begin
               tick();
               chk("t4_hold", out_data, {OUT_CH{16'h6C00}});
            end
            chk("t4_ready_low", in_ready, 1'b0);
            out_ready = 1'b1;
         end
      join
      drain();
      chk("t4_count", results_seen - r0, 2);
      chk("t4_last", last_out, {OUT_CH{16'h6C00}});

      // 5: clear aborts a partial window
      repeat (4) push_beat();
      clear = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      chk("t5_ready", in_ready, 1'b0);
      tick();
      clear = 1'b0;
      in_valid = 1'b0;
      chk("t5_tap", tap_idx, '0);
      r0 = results_seen;
      repeat (9) push_beat();
      drain();
      chk("t5_count", results_seen - r0, 1);
      chk("t5_data", last_out, {OUT_CH{16'h6C00}});

      // 6: asynchronous reset mid-window
      repeat (5) push_beat();
      rst_n = 1'b0;
      #1;
      chk("t6_valid", out_valid, 1'b0);
      chk("t6_data", out_data, '0);
      chk("t6_tap", tap_idx, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      repeat (9) push_beat();
      drain();
      chk("t6_fresh", last_out, {OUT_CH{16'h6C00}});

      // Randomised windows with random back-pressure, bias and ReLU
      for (int win = 0; win < 6; win++) begin
         for (int o = 0; o < OUT_CH; o++) bias[(OUT_CH-o)*W-1 -: W] = rnd_word(4096);
         relu_en = 1'($urandom_range(0, 1));
         rand_ready = 1'b1;
         for (int b = 0; b < TAPS; b++) begin
            for (int k = 0; k < IN_CH; k++) in_data[(IN_CH-k)*W-1 -: W] = rnd_word(2048);
            for (int j = 0; j < OUT_CH*IN_CH; j++) weight[(OUT_CH*IN_CH-j)*W-1 -: W] = rnd_word(2048);
            push_beat();
         end
         rand_ready = 1'b0;
         drain();
      end
      relu_en = 1'b0;
      chk("end_tap", tap_idx, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
